// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: fetch entry layout,
// PC increment, default reset PC and the request/response tracking states.
package fetch_pkg;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // IDLE: nothing outstanding; WAIT: response owed; DROP: owed response is stale
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } fetch_state_e;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order DEPTH-entry queue of fetched {pc, instr} pairs with a synchronous flush.
// Storage is not reset; only pointers and count are.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output logic [AW:0]  count,
  output fetch_entry_t head
);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, keeps at most one imem request outstanding and
// queues returned words for ID; redirects flush the queue and mark in-flight data stale.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int AW = $clog2(DEPTH);

  fetch_state_e state;
  fetch_state_e state_next;
  logic [31:0]  fetch_pc;
  logic [31:0]  pend_pc;
  logic         pend;
  logic         stale;
  logic         pop;
  logic         push;
  logic         grant;
  logic         room;
  logic         can_issue;
  logic [AW:0]  count;
  fetch_entry_t head;
  fetch_entry_t push_entry;

  assign pend  = (state != S_IDLE);
  assign stale = (state == S_DROP);

  assign pop  = out_valid & out_ready;
  assign push = imem_rvalid & pend & ~stale & ~redirect_valid;

  // An outstanding request already reserves a slot, so it counts toward occupancy
  assign room = ({1'b0, count} + {{(AW+1){1'b0}}, pend})
              < ((AW+2)'(DEPTH) + {{(AW+1){1'b0}}, pop});

  assign can_issue = (~pend | imem_rvalid) & room;
  assign imem_req  = ~reset & ~redirect_valid & can_issue;
  assign imem_addr = fetch_pc;
  assign grant     = imem_req & imem_gnt;

  assign out_valid = ~reset & (count != '0);
  assign out_instr = reset ? '0 : head.instr;
  assign out_pc    = reset ? '0 : head.pc;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (grant) state_next = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid)         state_next = grant ? S_WAIT : S_IDLE;
        else if (redirect_valid) state_next = S_DROP;
      end
      S_DROP: if (imem_rvalid)   state_next = grant ? S_WAIT : S_IDLE;
      default:                   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)               fetch_pc <= RESET_PC;
    else if (redirect_valid) fetch_pc <= align_pc(redirect_pc);
    else if (grant)          fetch_pc <= fetch_pc + PC_INC;
  end

  always_ff @(posedge clk) begin
    if (grant) pend_pc <= fetch_pc;
  end

  assign push_entry = '{pc: pend_pc, instr: imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .head       (head)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue; a small memory responder returns
// 0x1000_0000 + address after a programmable latency.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  logic        auto_rvalid = 1'b0;
  logic [31:0] auto_rdata = 32'h0;
  logic        rsp_busy = 1'b0;
  int          rsp_cnt = 0;
  logic [31:0] rsp_addr = 32'h0;
  int          mem_lat = 1;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready)
  );

  assign imem_rvalid = auto_rvalid;
  assign imem_rdata  = auto_rdata;

  // Memory: mem_lat=1 means the response is valid in the cycle after the grant
  always @(posedge clk) begin
    auto_rvalid <= 1'b0;
    if (rsp_busy) begin
      if (rsp_cnt <= 1) begin
        auto_rvalid <= 1'b1;
        auto_rdata  <= 32'h1000_0000 + rsp_addr;
        rsp_busy    <= 1'b0;
      end else begin
        rsp_cnt <= rsp_cnt - 1;
      end
    end
    if (imem_req && imem_gnt) begin
      if (mem_lat <= 1) begin
        auto_rvalid <= 1'b1;
        auto_rdata  <= 32'h1000_0000 + imem_addr;
      end else begin
        rsp_busy <= 1'b1;
        rsp_cnt  <= mem_lat - 1;
        rsp_addr <= imem_addr;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    imem_gnt = 1'b0;
    out_ready = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b want 0", imem_req); end
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_vec++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr got %h want 0", out_instr); end
    n_vec++; if (out_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc got %h want 0", out_pc); end
  endtask

  task automatic test_stream();
    do_reset();
    mem_lat = 1; imem_gnt = 1'b1; out_ready = 1'b1;
    reset = 1'b0;
    #1;
    n_vec++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL stream_first_req got %b want 1", imem_req); end
    n_vec++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL stream_first_addr got %h want 0", imem_addr); end
    @(negedge clk); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_early_valid got %b want 0", out_valid); end
    @(negedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d] got %b want 1", k, out_valid); end
      n_vec++; if (out_pc !== 32'(4 * k)) begin n_bad++; $display("FAIL stream_pc[%0d] got %h want %h", k, out_pc, 32'(4 * k)); end
      n_vec++; if (out_instr !== 32'h1000_0000 + 32'(4 * k)) begin n_bad++; $display("FAIL stream_instr[%0d] got %h want %h", k, out_instr, 32'h1000_0000 + 32'(4 * k)); end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_full();
    int grants = 0;
    do_reset();
    mem_lat = 1; imem_gnt = 1'b1; out_ready = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (imem_req && imem_gnt) grants++;
      @(negedge clk);
    end
    #1;
    n_vec++; if (grants !== 4) begin n_bad++; $display("FAIL full_grants got %0d want 4", grants); end
    n_vec++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL full_req got %b want 0", imem_req); end
    n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL full_valid got %b want 1", out_valid); end
    n_vec++; if (out_pc !== 32'h0) begin n_bad++; $display("FAIL full_head_pc got %h want 0", out_pc); end
    out_ready = 1'b1;
    #1;
    n_vec++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL full_pop_req got %b want 1", imem_req); end
    n_vec++; if (imem_addr !== 32'h10) begin n_bad++; $display("FAIL full_pop_addr got %h want 10", imem_addr); end
    @(negedge clk); #1;
    n_vec++; if (out_pc !== 32'h4) begin n_bad++; $display("FAIL full_next_pc got %h want 4", out_pc); end
  endtask

  task automatic test_redirect_pending();
    logic [31:0] first_addr = 32'hDEAD_BEEF;
    logic [31:0] first_pc = 32'hDEAD_BEEF;
    logic [31:0] first_instr = 32'hDEAD_BEEF;
    bit got_req = 0;
    bit got_out = 0;
    do_reset();
    mem_lat = 4; imem_gnt = 1'b1; out_ready = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    #1;
    n_vec++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL redir_cycle_req got %b want 0", imem_req); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_vec++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL redir_stale_req got %b want 0", imem_req); end
    for (int i = 0; i < 20 && !got_out; i++) begin
      if (!got_req && imem_req && imem_gnt) begin got_req = 1; first_addr = imem_addr; end
      if (out_valid) begin got_out = 1; first_pc = out_pc; first_instr = out_instr; end
      @(negedge clk); #1;
    end
    n_vec++; if (!got_out) begin n_bad++; $display("FAIL redir_timeout got no output want output within 20 cycles"); end
    n_vec++; if (first_addr !== 32'h200) begin n_bad++; $display("FAIL redir_req_addr got %h want 200", first_addr); end
    n_vec++; if (first_pc !== 32'h200) begin n_bad++; $display("FAIL redir_out_pc got %h want 200", first_pc); end
    n_vec++; if (first_instr !== 32'h1000_0200) begin n_bad++; $display("FAIL redir_out_instr got %h want 10000200", first_instr); end
  endtask

  task automatic test_redirect_coincident();
    do_reset();
    mem_lat = 1; imem_gnt = 1'b1; out_ready = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL coinc_pre_valid got %b want 1", out_valid); end
    n_vec++; if (imem_rvalid !== 1'b1) begin n_bad++; $display("FAIL coinc_pre_rvalid got %b want 1", imem_rvalid); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL coinc_flush_valid got %b want 0", out_valid); end
    n_vec++; if (imem_addr !== 32'h300) begin n_bad++; $display("FAIL coinc_req_addr got %h want 300", imem_addr); end
    n_vec++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL coinc_req got %b want 1", imem_req); end
    @(negedge clk); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL coinc_dropped_valid got %b want 0", out_valid); end
    @(negedge clk); #1;
    n_vec++; if (out_pc !== 32'h300) begin n_bad++; $display("FAIL coinc_out_pc got %h want 300", out_pc); end
    n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL coinc_out_valid got %b want 1", out_valid); end
  endtask

  task automatic test_wrap_align();
    do_reset();
    mem_lat = 1; imem_gnt = 1'b1; out_ready = 1'b1;
    reset = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1;
    n_vec++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL wrap_redir_req got %b want 0", imem_req); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_vec++; if (imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_top_addr got %h want fffffffc", imem_addr); end
    @(negedge clk); #1;
    n_vec++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_zero_addr got %h want 0", imem_addr); end
    @(negedge clk); #1;
    n_vec++; if (out_pc !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_out_pc got %h want fffffffc", out_pc); end
    n_vec++; if (out_instr !== 32'h0FFF_FFFC) begin n_bad++; $display("FAIL wrap_out_instr got %h want 0ffffffc", out_instr); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_vec++; if (imem_addr !== 32'h100) begin n_bad++; $display("FAIL align_addr got %h want 100", imem_addr); end
    n_vec++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL align_req got %b want 1", imem_req); end
  endtask

  task automatic test_reset_pending();
    bit got_out = 0;
    do_reset();
    mem_lat = 3; imem_gnt = 1'b1; out_ready = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_vec++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rstp_req got %b want 0", imem_req); end
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstp_valid got %b want 0", out_valid); end
    @(negedge clk);
    reset = 1'b0; imem_gnt = 1'b0;
    #1;
    n_vec++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL rstp_release_req got %b want 1", imem_req); end
    n_vec++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL rstp_release_addr got %h want 0", imem_addr); end
    @(negedge clk); #1;
    n_vec++; if (imem_rvalid !== 1'b1) begin n_bad++; $display("FAIL rstp_late_rvalid got %b want 1", imem_rvalid); end
    @(negedge clk); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstp_late_ignored got %b want 0", out_valid); end
    n_vec++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL rstp_addr_held got %h want 0", imem_addr); end
    mem_lat = 1; imem_gnt = 1'b1;
    for (int i = 0; i < 10 && !got_out; i++) begin
      @(negedge clk); #1;
      if (out_valid) got_out = 1;
    end
    n_vec++; if (!got_out) begin n_bad++; $display("FAIL rstp_timeout got no output want output within 10 cycles"); end
    n_vec++; if (out_pc !== 32'h0) begin n_bad++; $display("FAIL rstp_out_pc got %h want 0", out_pc); end
    n_vec++; if (out_instr !== 32'h1000_0000) begin n_bad++; $display("FAIL rstp_out_instr got %h want 10000000", out_instr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_pending();
    test_redirect_coincident();
    test_wrap_align();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
